// File: rtl/mist_video_out_stage_pkg.sv
// Shared types, csync encodings and colour expansion for the MiST video output stage.
package mist_video_out_stage_pkg;

    localparam logic CS_XOR = 1'b0;
    localparam logic CS_AND = 1'b1;

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank;
    } sync_bus_t;

    localparam sync_bus_t SYNC_IDLE = '{hs: 1'b0, vs: 1'b0, blank: 1'b1};

    // MSB-first replication of the in_d-bit value into out_d bits
    function automatic logic [7:0] expand(
        input logic [7:0] x,
        input int         in_d,
        input int         out_d
    );
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < out_d) begin
                r[3'(out_d - 1 - i)] = x[3'(in_d - 1 - (i % in_d))];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mist_video_out_stage_delay.sv
// Fixed-length shift register with synchronous reset to INIT; zero depth is a wire.
module video_delay_line #(
    parameter int               WIDTH = 3,
    parameter int               DEPTH = 3,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_clk;
            assign unused_clk = clk_sys ^ reset;
            assign dout = din;
        end else begin : g_sr
            logic [WIDTH-1:0] sr_q [DEPTH];
            logic [WIDTH-1:0] sr_d [DEPTH];

            always_comb begin
                sr_d[0] = din;
                for (int i = 1; i < DEPTH; i++) begin
                    sr_d[i] = sr_q[i-1];
                end
            end

            always_ff @(posedge clk_sys) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (reset) sr_q[i] <= INIT;
                    else       sr_q[i] <= sr_d[i];
                end
            end

            assign dout = sr_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/mist_video_out_stage_pol.sv
// Sync polarity detector: compares high and low phase lengths at each rising edge.
module sync_pol_detect #(
    parameter int CNT_WIDTH = 12
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic sync_in,
    output logic pol
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [CNT_WIDTH-1:0] hi_cnt_q, hi_cnt_d;
    logic [CNT_WIDTH-1:0] lo_cnt_q, lo_cnt_d;
    logic                 prev_q, prev_d;
    logic                 pol_q, pol_d;

    always_comb begin
        hi_cnt_d = hi_cnt_q;
        lo_cnt_d = lo_cnt_q;
        pol_d    = pol_q;
        prev_d   = sync_in;
        if (sync_in && !prev_q) begin
            if (hi_cnt_q != '0 && lo_cnt_q != '0) begin
                pol_d = hi_cnt_q < lo_cnt_q;
            end
            hi_cnt_d = CNT_WIDTH'(1);
            lo_cnt_d = '0;
        end else if (sync_in) begin
            if (hi_cnt_q != CNT_MAX) hi_cnt_d = hi_cnt_q + 1'b1;
        end else begin
            if (lo_cnt_q != CNT_MAX) lo_cnt_d = lo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hi_cnt_q <= '0;
            lo_cnt_q <= '0;
            prev_q   <= 1'b0;
            pol_q    <= 1'b0;
        end else begin
            hi_cnt_q <= hi_cnt_d;
            lo_cnt_q <= lo_cnt_d;
            prev_q   <= prev_d;
            pol_q    <= pol_d;
        end
    end

    assign pol = pol_q;

endmodule

// File: rtl/mist_video_out_stage.sv
// Final MiST video output: sync polarity detect, sync/blank delay, csync, blanking, colour expand.
module mist_video_out_stage
    import mist_video_out_stage_pkg::*;
#(
    parameter int   IN_DEPTH   = 6,
    parameter int   OUT_DEPTH  = 6,
    parameter int   SYNC_DELAY = 3,
    parameter int   CNT_WIDTH  = 12,
    parameter int   USE_BLANKS = 0,
    parameter logic HS_OUT_POL = 1'b0,
    parameter logic VS_OUT_POL = 1'b0
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 csync_en,
    input  logic                 sync_and,
    input  logic [IN_DEPTH-1:0]  R,
    input  logic [IN_DEPTH-1:0]  G,
    input  logic [IN_DEPTH-1:0]  B,
    input  logic                 HSync,
    input  logic                 VSync,
    input  logic                 HBlank,
    input  logic                 VBlank,
    output logic [OUT_DEPTH-1:0] VGA_R,
    output logic [OUT_DEPTH-1:0] VGA_G,
    output logic [OUT_DEPTH-1:0] VGA_B,
    output logic                 VGA_HS,
    output logic                 VGA_VS,
    output logic                 hs_pol,
    output logic                 vs_pol
);

    sync_bus_t      sync_raw, sync_dly;
    logic [2:0]     dly_w;
    logic           hs_a, vs_a, cs_a, hs_sel;
    logic [7:0]     r_x, g_x, b_x;
    logic           unused_x;

    logic [OUT_DEPTH-1:0] vga_r_q, vga_r_d;
    logic [OUT_DEPTH-1:0] vga_g_q, vga_g_d;
    logic [OUT_DEPTH-1:0] vga_b_q, vga_b_d;
    logic                 vga_hs_q, vga_hs_d;
    logic                 vga_vs_q, vga_vs_d;

    sync_pol_detect #(.CNT_WIDTH(CNT_WIDTH)) u_hs_pol (
        .clk_sys (clk_sys),
        .reset   (reset),
        .sync_in (HSync),
        .pol     (hs_pol)
    );

    sync_pol_detect #(.CNT_WIDTH(CNT_WIDTH)) u_vs_pol (
        .clk_sys (clk_sys),
        .reset   (reset),
        .sync_in (VSync),
        .pol     (vs_pol)
    );

    assign hs_a = HSync ^ ~hs_pol;
    assign vs_a = VSync ^ ~vs_pol;

    always_comb begin
        sync_raw.hs    = hs_a;
        sync_raw.vs    = vs_a;
        sync_raw.blank = (USE_BLANKS != 0) ? (HBlank | VBlank) : (hs_a | vs_a);
    end

    video_delay_line #(
        .WIDTH (3),
        .DEPTH (SYNC_DELAY),
        .INIT  (SYNC_IDLE)
    ) u_delay (
        .clk_sys (clk_sys),
        .reset   (reset),
        .din     (sync_raw),
        .dout    (dly_w)
    );

    assign sync_dly = sync_bus_t'(dly_w);

    always_comb begin
        cs_a   = (sync_and == CS_AND) ? (sync_dly.hs | sync_dly.vs)
                                      : (sync_dly.hs ^ sync_dly.vs);
        hs_sel = csync_en ? cs_a : sync_dly.hs;
        r_x    = expand(8'(R), IN_DEPTH, OUT_DEPTH);
        g_x    = expand(8'(G), IN_DEPTH, OUT_DEPTH);
        b_x    = expand(8'(B), IN_DEPTH, OUT_DEPTH);

        vga_hs_d = hs_sel ? HS_OUT_POL : ~HS_OUT_POL;
        vga_vs_d = csync_en ? 1'b1 : (sync_dly.vs ? VS_OUT_POL : ~VS_OUT_POL);
        vga_r_d  = sync_dly.blank ? '0 : r_x[OUT_DEPTH-1:0];
        vga_g_d  = sync_dly.blank ? '0 : g_x[OUT_DEPTH-1:0];
        vga_b_d  = sync_dly.blank ? '0 : b_x[OUT_DEPTH-1:0];
    end

    // upper expansion bits are dead when OUT_DEPTH < 8
    assign unused_x = ^{r_x, g_x, b_x};

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            vga_r_q  <= '0;
            vga_g_q  <= '0;
            vga_b_q  <= '0;
            vga_hs_q <= ~HS_OUT_POL;
            vga_vs_q <= ~VS_OUT_POL;
        end else begin
            vga_r_q  <= vga_r_d;
            vga_g_q  <= vga_g_d;
            vga_b_q  <= vga_b_d;
            vga_hs_q <= vga_hs_d;
            vga_vs_q <= vga_vs_d;
        end
    end

    assign VGA_R  = vga_r_q;
    assign VGA_G  = vga_g_q;
    assign VGA_B  = vga_b_q;
    assign VGA_HS = vga_hs_q;
    assign VGA_VS = vga_vs_q;

endmodule

// File: tb/tb_mist_video_out_stage.sv
// Directed bench for mist_video_out_stage: three instances with delays 3, 0 and 15.
module tb_mist_video_out_stage;

    logic       clk_sys = 1'b0;
    logic       reset, csync_en, sync_and;
    logic       hsync, vsync, hblank, vblank;
    logic [5:0] r;

    logic [7:0] a_r, a_g, a_b;
    logic       a_hs, a_vs, a_hp, a_vp;
    logic [5:0] b_r, b_g, b_b;
    logic       b_hs, b_vs, b_hp, b_vp;
    logic [5:0] c_r, c_g, c_b;
    logic       c_hs, c_vs, c_hp, c_vp;

    int   cyc, nchk, nerr, in_cyc;
    int   fall [3];
    int   len  [3];
    logic prev_hs [3];

    always #5 clk_sys = ~clk_sys;

    mist_video_out_stage #(
        .IN_DEPTH(6), .OUT_DEPTH(8), .SYNC_DELAY(3), .USE_BLANKS(1)
    ) dut_a (
        .clk_sys(clk_sys), .reset(reset), .csync_en(csync_en), .sync_and(sync_and),
        .R(r), .G(r), .B(r), .HSync(hsync), .VSync(vsync),
        .HBlank(hblank), .VBlank(vblank),
        .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b), .VGA_HS(a_hs), .VGA_VS(a_vs),
        .hs_pol(a_hp), .vs_pol(a_vp)
    );

    mist_video_out_stage #(
        .IN_DEPTH(6), .OUT_DEPTH(6), .SYNC_DELAY(0), .USE_BLANKS(0)
    ) dut_b (
        .clk_sys(clk_sys), .reset(reset), .csync_en(csync_en), .sync_and(sync_and),
        .R(r), .G(r), .B(r), .HSync(hsync), .VSync(vsync),
        .HBlank(hblank), .VBlank(vblank),
        .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b), .VGA_HS(b_hs), .VGA_VS(b_vs),
        .hs_pol(b_hp), .vs_pol(b_vp)
    );

    mist_video_out_stage #(
        .IN_DEPTH(6), .OUT_DEPTH(6), .SYNC_DELAY(15), .USE_BLANKS(0)
    ) dut_c (
        .clk_sys(clk_sys), .reset(reset), .csync_en(csync_en), .sync_and(sync_and),
        .R(r), .G(r), .B(r), .HSync(hsync), .VSync(vsync),
        .HBlank(hblank), .VBlank(vblank),
        .VGA_R(c_r), .VGA_G(c_g), .VGA_B(c_b), .VGA_HS(c_hs), .VGA_VS(c_vs),
        .hs_pol(c_hp), .vs_pol(c_vp)
    );

    typedef struct {
        logic       cs;
        logic       sa;
        logic       h;
        logic       v;
        logic       hb;
        logic [5:0] r;
        logic       e_hs;
        logic       e_vs;
        logic [7:0] e_r8;
        logic [5:0] e_r6;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s @cyc %0d: got 'h%0h, expected 'h%0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        logic now [3];
        @(posedge clk_sys);
        #1;
        cyc++;
        now[0] = a_hs;
        now[1] = b_hs;
        now[2] = c_hs;
        for (int d = 0; d < 3; d++) begin
            if (prev_hs[d] && !now[d]) fall[d] = cyc;
            if (!prev_hs[d] && now[d]) len[d] = cyc - fall[d];
            prev_hs[d] = now[d];
        end
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_line(input logic act_high, input int n);
        for (int i = 0; i < n; i++) begin
            hsync = (i < 96) ? act_high : ~act_high;
            if (i == 0) in_cyc = cyc;
            step();
        end
    endtask

    task automatic check_line(input string tag);
        chk({tag, "_len_a"}, len[0], 96);
        chk({tag, "_len_c"}, len[2], 96);
        chk({tag, "_lat_a"}, fall[0] - in_cyc, 4);
        chk({tag, "_lat_b"}, fall[1] - in_cyc, 1);
        chk({tag, "_lat_c"}, fall[2] - in_cyc, 16);
    endtask

    initial begin
        cyc = 0; nchk = 0; nerr = 0; in_cyc = 0;
        for (int d = 0; d < 3; d++) begin
            fall[d] = 0; len[d] = 0; prev_hs[d] = 1'b1;
        end
        reset = 1'b1; csync_en = 1'b0; sync_and = 1'b0;
        hsync = 1'b1; vsync = 1'b1; hblank = 1'b0; vblank = 1'b0;
        r = 6'h2A;

        //             cs    sa    h     v     hb    r      ehs   evs   er8    er6
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'h2A, 1'b1, 1'b1, 8'hAA, 6'h2A};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'h3F, 1'b0, 1'b1, 8'hFF, 6'h00};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'h15, 1'b1, 1'b1, 8'h00, 6'h15};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'h01, 1'b1, 1'b0, 8'h04, 6'h00};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'h20, 1'b1, 1'b1, 8'h82, 6'h20};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'h15, 1'b0, 1'b1, 8'h55, 6'h00};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'h15, 1'b1, 1'b1, 8'h55, 6'h15};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h15, 1'b1, 1'b1, 8'h55, 6'h00};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'h15, 1'b0, 1'b1, 8'h55, 6'h00};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6'h2A, 1'b1, 1'b1, 8'hAA, 6'h2A};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'h2A, 1'b0, 1'b1, 8'hAA, 6'h00};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'h2A, 1'b0, 1'b1, 8'hAA, 6'h00};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'h2A, 1'b0, 1'b1, 8'hAA, 6'h00};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'h2A, 1'b1, 1'b1, 8'h00, 6'h2A};

        hold(2);
        chk("rst_a_r", int'(a_r), 0);
        chk("rst_a_g", int'(a_g), 0);
        chk("rst_a_hs", int'(a_hs), 1);
        chk("rst_a_vs", int'(a_vs), 1);
        chk("rst_hs_pol", int'(a_hp), 0);
        chk("rst_vs_pol", int'(a_vp), 0);
        reset = 1'b0;
        hold(200);

        for (int k = 0; k < 14; k++) begin
            csync_en = tbl[k].cs;
            sync_and = tbl[k].sa;
            hsync    = tbl[k].h;
            vsync    = tbl[k].v;
            hblank   = tbl[k].hb;
            r        = tbl[k].r;
            hold(20);
            chk($sformatf("v%0d_a_hs", k), int'(a_hs), int'(tbl[k].e_hs));
            chk($sformatf("v%0d_a_vs", k), int'(a_vs), int'(tbl[k].e_vs));
            chk($sformatf("v%0d_a_r", k), int'(a_r), int'(tbl[k].e_r8));
            chk($sformatf("v%0d_a_g", k), int'(a_g), int'(tbl[k].e_r8));
            chk($sformatf("v%0d_b_hs", k), int'(b_hs), int'(tbl[k].e_hs));
            chk($sformatf("v%0d_b_r", k), int'(b_r), int'(tbl[k].e_r6));
            chk($sformatf("v%0d_c_hs", k), int'(c_hs), int'(tbl[k].e_hs));
            chk($sformatf("v%0d_c_vs", k), int'(c_vs), int'(tbl[k].e_vs));
        end
        chk("tbl_hs_pol", int'(a_hp), 0);
        chk("tbl_vs_pol", int'(a_vp), 0);

        csync_en = 1'b0; sync_and = 1'b0; hblank = 1'b0; r = 6'h2A;
        hold(20);
        chk("col_pre", int'(a_r), 'hAA);
        r = 6'h15;
        step();
        chk("col_lat_a", int'(a_r), 'h55);
        chk("col_lat_b", int'(b_r), 'h15);
        r = 6'h2A;
        for (int k = 0; k < 20; k++) begin
            hblank = (k < 10);
            step();
            chk($sformatf("hblank_%0d", k), int'(a_r), (k >= 3 && k <= 12) ? 0 : 'hAA);
        end

        run_line(1'b0, 800);
        run_line(1'b0, 800);
        chk("lo_pol_l2", int'(a_hp), 0);
        run_line(1'b0, 800);
        chk("lo_pol_l3", int'(a_hp), 0);
        check_line("lo");

        hsync = 1'b1;
        hold(5000);
        hsync = 1'b0;
        hold(2000);
        hsync = 1'b1;
        hold(10);
        chk("sat_hs_pol", int'(a_hp), 0);
        chk("sat_vs_pol", int'(a_vp), 0);

        reset = 1'b1; hsync = 1'b0;
        hold(2);
        reset = 1'b0;
        hold(20);
        run_line(1'b1, 800);
        run_line(1'b1, 800);
        chk("hi_pol_l2", int'(a_hp), 1);
        run_line(1'b1, 800);
        chk("hi_pol_l3", int'(a_hp), 1);
        check_line("hi");

        run_line(1'b1, 50);
        chk("mid_a_hs", int'(a_hs), 0);
        chk("mid_a_r", int'(a_r), 'hAA);
        reset = 1'b1;
        step();
        chk("mrst_a_r", int'(a_r), 0);
        chk("mrst_a_hs", int'(a_hs), 1);
        chk("mrst_a_vs", int'(a_vs), 1);
        chk("mrst_b_hs", int'(b_hs), 1);
        chk("mrst_c_hs", int'(c_hs), 1);
        chk("mrst_hs_pol", int'(a_hp), 0);
        reset = 1'b0;
        hold(10);
        chk("post_hs_pol", int'(a_hp), 0);
        chk("post_a_hs", int'(a_hs), 1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
